// File: rtl/trig_dist_pkg.sv
// Shared types, register map and modular-add helper for the trigger distribution node.
package trig_dist_pkg;

    typedef struct packed {
        logic [15:0] id;
        logic [3:0]  rsvd;
        logic [27:0] cycles;
    } trig_msg_t;

    localparam logic [5:0] REG_TTX_CR      = 6'h00;
    localparam logic [5:0] REG_TTX_ADJ_C   = 6'h04;
    localparam logic [5:0] REG_TTX_ADJ_F   = 6'h08;
    localparam logic [5:0] REG_TTX_CNT     = 6'h0C;
    localparam logic [5:0] REG_TRX_CR      = 6'h10;
    localparam logic [5:0] REG_TRX_DELAY_C = 6'h14;
    localparam logic [5:0] REG_TRX_DELAY_F = 6'h18;
    localparam logic [5:0] REG_TRX_CNT     = 6'h1C;
    localparam logic [5:0] REG_TRX_MISS    = 6'h20;

    localparam int CR_ENABLE   = 0;
    localparam int CR_RST_CNT  = 1;
    localparam int CR_RST_HIST = 2;

    // Both operands are already below n, so one conditional subtract is enough.
    function automatic logic [27:0] add_mod(input logic [27:0] a, input logic [27:0] b,
                                            input logic [27:0] n);
        logic [28:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= {1'b0, n}) s = s - {1'b0, n};
        return s[27:0];
    endfunction

endpackage

// File: rtl/trig_dist_if.sv
// Stream (TX/RX message) and host register bus bundle for trig_dist_node.
interface trig_dist_if;
    logic [47:0] tx_msg;
    logic        tx_valid;
    logic        tx_ready;
    logic [47:0] rx_msg;
    logic        rx_valid;
    logic        reg_stb;
    logic        reg_we;
    logic [5:0]  reg_addr;
    logic [31:0] reg_wdata;
    logic [31:0] reg_rdata;
    logic        reg_ack;

    // tx_msg is held stable while tx_valid=1 and transfers on a cycle with tx_valid && tx_ready;
    // rx_msg is accepted on every cycle rx_valid=1; reg_stb is held until reg_ack (one cycle pulse).
    modport slave (
        output tx_msg, tx_valid, reg_rdata, reg_ack,
        input  tx_ready, rx_msg, rx_valid, reg_stb, reg_we, reg_addr, reg_wdata
    );

    modport master (
        input  tx_msg, tx_valid, reg_rdata, reg_ack,
        output tx_ready, rx_msg, rx_valid, reg_stb, reg_we, reg_addr, reg_wdata
    );
endinterface

// File: rtl/trig_dist_fifo.sv
// Synchronous ring FIFO of due times; push while full is accepted only alongside a pop.
module trig_dist_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 28
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem_q [DEPTH];
    logic [W-1:0] mem_d [DEPTH];
    logic [AW:0]  wr_ptr_q, wr_ptr_d;
    logic [AW:0]  rd_ptr_q, rd_ptr_d;
    logic         do_push, do_pop;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign dout  = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        do_pop   = pop && !empty;
        do_push  = push && (!full || do_pop);
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q[AW-1:0]] = din;
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (do_pop) rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            mem_q    <= mem_d;
        end
    end
endmodule

// File: rtl/trig_dist_node.sv
// Trigger distribution node: timestamps trigger edges for TX, schedules delayed pulses from RX.
// Optional TRIG_DIST_MISS_EN adds TX drop count (TTX_CNT[31:16]) and TRX_MISS at 0x20.
module trig_dist_node
    import trig_dist_pkg::*;
#(
    parameter int CYCLES_PER_SEC = 62_500_000,
    parameter int FIFO_DEPTH     = 4,
    parameter int PULSE_LEN      = 4
) (
    input  logic        clk_sys_i,
    input  logic        rst_sys_i,
    input  logic [27:0] tm_cycles_i,
    input  logic        tm_valid_i,
    input  logic        trig_i,
    output logic        pulse_o,
    output logic [11:0] pulse_fine_o,
    output logic [11:0] ts_fine_o,
    trig_dist_if.slave  bus
);
    localparam logic [27:0] N_C = 28'(CYCLES_PER_SEC);

    function automatic logic [27:0] sat_cycles(input logic [31:0] v);
        return (v >= {4'b0, N_C}) ? N_C - 28'd1 : v[27:0];
    endfunction

    logic [2:0]  trig_sync_q, trig_sync_d;
    logic        edge_q, edge_d;
    logic        ttx_en_q, ttx_en_d, trx_en_q, trx_en_d;
    logic [15:0] ttx_id_q, ttx_id_d, trx_id_q, trx_id_d;
    logic [27:0] ttx_adj_c_q, ttx_adj_c_d, trx_delay_c_q, trx_delay_c_d;
    logic [11:0] ttx_adj_f_q, ttx_adj_f_d, trx_delay_f_q, trx_delay_f_d;
    logic [15:0] ttx_cnt_q, ttx_cnt_d;
    logic [31:0] trx_cnt_q, trx_cnt_d;
    logic        tx_valid_q, tx_valid_d;
    trig_msg_t   tx_msg_q, tx_msg_d;
    logic [7:0]  pulse_cnt_q, pulse_cnt_d;
    logic        ack_q, ack_d;
    logic [31:0] rdata_q, rdata_d;

    logic        wr, rst_ttx_cnt, rst_trx_cnt, rst_hist;
    logic        capture_req, rx_match, fire;
    logic        fifo_push, fifo_full, fifo_empty;
    logic [27:0] fifo_head;
    logic [15:0] ttx_drop_w;
    logic [31:0] trx_miss_w;
    trig_msg_t   rx_msg;

    assign rx_msg = bus.rx_msg;

    trig_dist_fifo #(.DEPTH(FIFO_DEPTH), .W(28)) u_fifo (
        .clk   (clk_sys_i),
        .rst   (rst_sys_i),
        .flush (rst_hist),
        .push  (fifo_push),
        .pop   (fire),
        .din   (add_mod(rx_msg.cycles, trx_delay_c_q, N_C)),
        .dout  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        trig_sync_d   = {trig_sync_q[1:0], trig_i};
        edge_d        = trig_sync_q[1] & ~trig_sync_q[2];
        ttx_en_d      = ttx_en_q;
        ttx_id_d      = ttx_id_q;
        ttx_adj_c_d   = ttx_adj_c_q;
        ttx_adj_f_d   = ttx_adj_f_q;
        trx_en_d      = trx_en_q;
        trx_id_d      = trx_id_q;
        trx_delay_c_d = trx_delay_c_q;
        trx_delay_f_d = trx_delay_f_q;
        ttx_cnt_d     = ttx_cnt_q;
        trx_cnt_d     = trx_cnt_q;
        tx_valid_d    = tx_valid_q;
        tx_msg_d      = tx_msg_q;
        pulse_cnt_d   = pulse_cnt_q;
        rst_ttx_cnt   = 1'b0;
        rst_trx_cnt   = 1'b0;
        rst_hist      = 1'b0;
        wr            = bus.reg_stb && bus.reg_we && !ack_q;

        if (wr) begin
            case (bus.reg_addr)
                REG_TTX_CR: begin
                    ttx_en_d    = bus.reg_wdata[CR_ENABLE];
                    ttx_id_d    = bus.reg_wdata[31:16];
                    rst_ttx_cnt = bus.reg_wdata[CR_RST_CNT];
                end
                REG_TTX_ADJ_C:   ttx_adj_c_d   = sat_cycles(bus.reg_wdata);
                REG_TTX_ADJ_F:   ttx_adj_f_d   = bus.reg_wdata[11:0];
                REG_TRX_CR: begin
                    trx_en_d    = bus.reg_wdata[CR_ENABLE];
                    trx_id_d    = bus.reg_wdata[31:16];
                    rst_trx_cnt = bus.reg_wdata[CR_RST_CNT];
                    rst_hist    = bus.reg_wdata[CR_RST_HIST];
                end
                REG_TRX_DELAY_C: trx_delay_c_d = sat_cycles(bus.reg_wdata);
                REG_TRX_DELAY_F: trx_delay_f_d = bus.reg_wdata[11:0];
                default: ;
            endcase
        end

        // The handshake cycle still counts as pending, so an edge landing then is dropped.
        capture_req = edge_q && ttx_en_q && tm_valid_i;
        if (tx_valid_q && bus.tx_ready) begin
            tx_valid_d = 1'b0;
            ttx_cnt_d  = ttx_cnt_q + 16'd1;
        end
        if (capture_req && !tx_valid_q) begin
            tx_valid_d = 1'b1;
            tx_msg_d   = '{id: ttx_id_q, rsvd: 4'b0,
                           cycles: add_mod(tm_cycles_i, ttx_adj_c_q, N_C)};
        end
        if (rst_ttx_cnt) ttx_cnt_d = '0;

        rx_match  = bus.rx_valid && trx_en_q && (rx_msg.id == trx_id_q);
        fire      = !fifo_empty && tm_valid_i && (tm_cycles_i == fifo_head);
        fifo_push = rx_match && !rst_hist && (!fifo_full || fire);
        if (fifo_push) trx_cnt_d = trx_cnt_q + 32'd1;
        if (rst_trx_cnt) trx_cnt_d = '0;

        if (fire) pulse_cnt_d = 8'(PULSE_LEN);
        else if (pulse_cnt_q != 8'd0) pulse_cnt_d = pulse_cnt_q - 8'd1;

        ack_d   = bus.reg_stb && !ack_q;
        rdata_d = '0;
        if (bus.reg_stb && !ack_q) begin
            case (bus.reg_addr)
                REG_TTX_CR:      rdata_d = {ttx_id_q, 15'b0, ttx_en_q};
                REG_TTX_ADJ_C:   rdata_d = {4'b0, ttx_adj_c_q};
                REG_TTX_ADJ_F:   rdata_d = {20'b0, ttx_adj_f_q};
                REG_TTX_CNT:     rdata_d = {ttx_drop_w, ttx_cnt_q};
                REG_TRX_CR:      rdata_d = {trx_id_q, 15'b0, trx_en_q};
                REG_TRX_DELAY_C: rdata_d = {4'b0, trx_delay_c_q};
                REG_TRX_DELAY_F: rdata_d = {20'b0, trx_delay_f_q};
                REG_TRX_CNT:     rdata_d = trx_cnt_q;
                REG_TRX_MISS:    rdata_d = trx_miss_w;
                default:         rdata_d = '0;
            endcase
        end
    end

`ifdef TRIG_DIST_MISS_EN
    logic [15:0] ttx_drop_q, ttx_drop_d;
    logic [31:0] trx_miss_q, trx_miss_d;

    always_comb begin
        ttx_drop_d = ttx_drop_q;
        trx_miss_d = trx_miss_q;
        if (capture_req && tx_valid_q) ttx_drop_d = ttx_drop_q + 16'd1;
        if (rx_match && !rst_hist && fifo_full && !fire) trx_miss_d = trx_miss_q + 32'd1;
        if (rst_ttx_cnt) ttx_drop_d = '0;
        if (rst_trx_cnt) trx_miss_d = '0;
    end

    always_ff @(posedge clk_sys_i) begin
        if (rst_sys_i) begin
            ttx_drop_q <= '0;
            trx_miss_q <= '0;
        end else begin
            ttx_drop_q <= ttx_drop_d;
            trx_miss_q <= trx_miss_d;
        end
    end

    assign ttx_drop_w = ttx_drop_q;
    assign trx_miss_w = trx_miss_q;
`else
    assign ttx_drop_w = '0;
    assign trx_miss_w = '0;
`endif

    always_ff @(posedge clk_sys_i) begin
        if (rst_sys_i) begin
            trig_sync_q   <= '0;
            edge_q        <= 1'b0;
            ttx_en_q      <= 1'b0;
            ttx_id_q      <= '0;
            ttx_adj_c_q   <= '0;
            ttx_adj_f_q   <= '0;
            trx_en_q      <= 1'b0;
            trx_id_q      <= '0;
            trx_delay_c_q <= '0;
            trx_delay_f_q <= '0;
            ttx_cnt_q     <= '0;
            trx_cnt_q     <= '0;
            tx_valid_q    <= 1'b0;
            tx_msg_q      <= '0;
            pulse_cnt_q   <= '0;
            ack_q         <= 1'b0;
            rdata_q       <= '0;
        end else begin
            trig_sync_q   <= trig_sync_d;
            edge_q        <= edge_d;
            ttx_en_q      <= ttx_en_d;
            ttx_id_q      <= ttx_id_d;
            ttx_adj_c_q   <= ttx_adj_c_d;
            ttx_adj_f_q   <= ttx_adj_f_d;
            trx_en_q      <= trx_en_d;
            trx_id_q      <= trx_id_d;
            trx_delay_c_q <= trx_delay_c_d;
            trx_delay_f_q <= trx_delay_f_d;
            ttx_cnt_q     <= ttx_cnt_d;
            trx_cnt_q     <= trx_cnt_d;
            tx_valid_q    <= tx_valid_d;
            tx_msg_q      <= tx_msg_d;
            pulse_cnt_q   <= pulse_cnt_d;
            ack_q         <= ack_d;
            rdata_q       <= rdata_d;
        end
    end

    assign pulse_o       = (pulse_cnt_q != 8'd0);
    assign pulse_fine_o  = pulse_o ? trx_delay_f_q : 12'd0;
    assign ts_fine_o     = ttx_adj_f_q;
    assign bus.tx_msg    = tx_msg_q;
    assign bus.tx_valid  = tx_valid_q;
    assign bus.reg_rdata = rdata_q;
    assign bus.reg_ack   = ack_q;
endmodule

// File: tb/tb_trig_dist_node.sv
// Directed bench for trig_dist_node: registers, TX timestamping, RX delay/wrap, FIFO limits, reset.
module tb_trig_dist_node;
    localparam int N = 62_500_000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [27:0] tm = '0;
    logic        tm_valid = 1'b0;
    logic        tm_run = 1'b0;
    logic        trig = 1'b0;
    logic        pulse_o;
    logic [11:0] pulse_fine_o, ts_fine_o;
    int          checks = 0;
    int          failures = 0;

    trig_dist_if bus();

    trig_dist_node dut (
        .clk_sys_i    (clk),
        .rst_sys_i    (rst),
        .tm_cycles_i  (tm),
        .tm_valid_i   (tm_valid),
        .trig_i       (trig),
        .pulse_o      (pulse_o),
        .pulse_fine_o (pulse_fine_o),
        .ts_fine_o    (ts_fine_o),
        .bus          (bus)
    );

    always #8 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
        if (tm_run) tm = (tm == 28'(N - 1)) ? 28'd0 : tm + 28'd1;
    endtask

    task automatic reg_access(input logic we, input logic [5:0] addr, input logic [31:0] wdata,
                              output logic [31:0] rdata);
        bit got;
        got = 0;
        bus.reg_stb = 1'b1; bus.reg_we = we; bus.reg_addr = addr; bus.reg_wdata = wdata;
        rdata = '0;
        for (int i = 0; i < 4 && !got; i++) begin
            step();
            if (bus.reg_ack) begin got = 1; rdata = bus.reg_rdata; end
        end
        bus.reg_stb = 1'b0; bus.reg_we = 1'b0;
        if (!got) begin
            failures++;
            $display("FAIL reg_ack_timeout addr=%h", addr);
        end
        step();
    endtask

    task automatic reg_write(input logic [5:0] addr, input logic [31:0] data);
        logic [31:0] dummy;
        reg_access(1'b1, addr, data, dummy);
    endtask

    task automatic check_reg(input string name, input logic [5:0] addr, input logic [31:0] exp);
        logic [31:0] v;
        reg_access(1'b0, addr, 32'd0, v);
        checks++;
        if (v !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", name, v, exp);
        end
    endtask

    task automatic send_rx(input logic [15:0] id, input logic [27:0] cyc);
        bus.rx_msg = {id, 4'b0, cyc};
        bus.rx_valid = 1'b1;
        step();
        bus.rx_valid = 1'b0;
    endtask

    // Waits for pulse_o, returns timebase value that triggered it, its width and fine value.
    task automatic wait_pulse(input int max, output bit seen, output logic [27:0] fire_tm,
                              output int width, output logic [11:0] fine);
        seen = 0; fire_tm = '0; width = 0; fine = '0;
        for (int i = 0; i < max && !seen; i++) begin
            step();
            if (pulse_o) begin
                seen = 1;
                fire_tm = (tm == 28'd0) ? 28'(N - 1) : tm - 28'd1;
                fine = pulse_fine_o;
            end
        end
        if (seen) begin
            width = 1;
            for (int i = 0; i < 20; i++) begin
                step();
                if (pulse_o) width++;
                else break;
            end
        end
    endtask

    task automatic check_pulse(input string name, input int max, input logic [27:0] exp_tm);
        bit seen; logic [27:0] ft; int w; logic [11:0] f;
        wait_pulse(max, seen, ft, w, f);
        checks++;
        if (!seen || ft !== exp_tm) begin
            failures++;
            $display("FAIL %s_time seen=%0d got=%0d exp=%0d", name, seen, ft, exp_tm);
        end
        checks++;
        if (w != 4) begin
            failures++;
            $display("FAIL %s_width got=%0d exp=4", name, w);
        end
    endtask

    task automatic wait_tx(input string name, input logic [47:0] exp);
        bit seen;
        seen = 0;
        for (int i = 0; i < 10 && !seen; i++) begin
            step();
            if (bus.tx_valid) seen = 1;
        end
        checks++;
        if (!seen || bus.tx_msg !== exp) begin
            failures++;
            $display("FAIL %s valid=%0d got=%h exp=%h", name, seen, bus.tx_msg, exp);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step(); step();
        checks++;
        if (pulse_o !== 1'b0 || bus.tx_valid !== 1'b0 || bus.reg_ack !== 1'b0) begin
            failures++;
            $display("FAIL reset_outputs got=%b%b%b exp=000", pulse_o, bus.tx_valid, bus.reg_ack);
        end
        rst = 1'b0;
        step();
        check_reg("reset_ttx_cnt", 6'h0C, 32'd0);
        check_reg("reset_trx_cr", 6'h10, 32'd0);
    endtask

    task automatic test_regs();
        reg_write(6'h04, 32'hFFFF_FFFF);
        check_reg("adj_c_saturate", 6'h04, 32'd62_499_999);
        reg_write(6'h14, 32'd62_500_000);
        check_reg("delay_c_saturate", 6'h14, 32'd62_499_999);
        reg_write(6'h00, (32'd11 << 16) | 32'd3);
        check_reg("ttx_cr_readback", 6'h00, (32'd11 << 16) | 32'd1);
        reg_write(6'h24, 32'hDEAD_BEEF);
        check_reg("unmapped_read", 6'h24, 32'd0);
        check_reg("miss_initial", 6'h20, 32'd0);
    endtask

    task automatic test_tx();
        tm_valid = 1'b1; tm_run = 1'b1; bus.tx_ready = 1'b0;
        reg_write(6'h04, 32'd0);
        reg_write(6'h08, 32'h123);
        tm = 28'd1000; trig = 1'b1;
        wait_tx("tx_msg_1003", {16'd11, 4'b0, 28'd1003});
        checks++;
        if (ts_fine_o !== 12'h123) begin
            failures++;
            $display("FAIL ts_fine got=%h exp=123", ts_fine_o);
        end
        trig = 1'b0; step(); step(); step(); step();
        trig = 1'b1;
        for (int i = 0; i < 6; i++) step();
        checks++;
        if (bus.tx_valid !== 1'b1 || bus.tx_msg !== {16'd11, 4'b0, 28'd1003}) begin
            failures++;
            $display("FAIL tx_drop_pending got=%h exp=%h", bus.tx_msg, {16'd11, 4'b0, 28'd1003});
        end
        bus.tx_ready = 1'b1; step(); bus.tx_ready = 1'b0;
        checks++;
        if (bus.tx_valid !== 1'b0) begin
            failures++;
            $display("FAIL tx_valid_after_ready got=%b exp=0", bus.tx_valid);
        end
`ifdef TRIG_DIST_MISS_EN
        check_reg("ttx_cnt_one", 6'h0C, 32'h0001_0001);
`else
        check_reg("ttx_cnt_one", 6'h0C, 32'd1);
`endif
        // Adjustment at the top of the range wraps: 1003 + (N-1) -> 1002.
        reg_write(6'h04, 32'd62_499_999);
        trig = 1'b0; step(); step(); step(); step();
        tm = 28'd1000; trig = 1'b1;
        wait_tx("tx_msg_wrap_adj", {16'd11, 4'b0, 28'd1002});
        bus.tx_ready = 1'b1; step(); bus.tx_ready = 1'b0;
        trig = 1'b0;
        reg_write(6'h00, (32'd11 << 16) | 32'd3);
        check_reg("ttx_cnt_rst", 6'h0C, 32'd0);
    endtask

    task automatic test_rx_delay();
        reg_write(6'h10, (32'd11 << 16) | 32'd1);
        reg_write(6'h14, 32'd2000);
        reg_write(6'h18, 32'h0AB);
        send_rx(16'd11, 28'd500);
        tm = 28'd2400;
        begin
            bit seen; logic [27:0] ft; int w; logic [11:0] f;
            wait_pulse(200, seen, ft, w, f);
            checks++;
            if (!seen || ft !== 28'd2500 || w != 4 || f !== 12'h0AB) begin
                failures++;
                $display("FAIL rx_delay seen=%0d tm=%0d width=%0d fine=%h exp tm=2500 width=4 fine=0ab",
                         seen, ft, w, f);
            end
        end
    endtask

    task automatic test_wrap();
        send_rx(16'd11, 28'd62_499_000);
        tm = 28'd900;
        check_pulse("rx_wrap", 200, 28'd1000);
    endtask

    task automatic test_back_to_back();
        logic [27:0] rises[$];
        logic prev;
        send_rx(16'd11, 28'd3000);
        send_rx(16'd12, 28'd3500);
        send_rx(16'd11, 28'd4070);
        tm = 28'd4990; prev = 1'b0;
        for (int i = 0; i < 1300; i++) begin
            step();
            if (pulse_o && !prev) rises.push_back(tm - 28'd1);
            prev = pulse_o;
        end
        checks++;
        if (rises.size() != 2) begin
            failures++;
            $display("FAIL two_pulses_count got=%0d exp=2", rises.size());
        end else begin
            checks++;
            if (rises[0] !== 28'd5000 || rises[1] !== 28'd6070) begin
                failures++;
                $display("FAIL two_pulses_times got=%0d,%0d exp=5000,6070", rises[0], rises[1]);
            end
        end
    endtask

    task automatic count_rises(input int steps, output int n);
        logic prev;
        prev = 1'b0; n = 0;
        for (int i = 0; i < steps; i++) begin
            step();
            if (pulse_o && !prev) n++;
            prev = pulse_o;
        end
    endtask

    task automatic test_fifo_full();
        int n;
        reg_write(6'h10, (32'd11 << 16) | 32'd3);
        tm_run = 1'b0; tm = 28'd0;
        for (int i = 0; i < 5; i++) send_rx(16'd11, 28'(10000 + 10 * i));
        check_reg("trx_cnt_full", 6'h1C, 32'd4);
`ifdef TRIG_DIST_MISS_EN
        check_reg("trx_miss", 6'h20, 32'd1);
`else
        check_reg("trx_miss", 6'h20, 32'd0);
`endif
        tm = 28'd11990; tm_run = 1'b1;
        count_rises(70, n);
        checks++;
        if (n != 4) begin
            failures++;
            $display("FAIL fifo_full_pulses got=%0d exp=4", n);
        end
        tm_run = 1'b0; tm = 28'd0;
        for (int i = 0; i < 5; i++) send_rx(16'd11, 28'(10000 + i));
        reg_write(6'h10, (32'd11 << 16) | 32'd5);
        tm = 28'd11990; tm_run = 1'b1;
        count_rises(40, n);
        checks++;
        if (n != 0) begin
            failures++;
            $display("FAIL rst_hist_pulses got=%0d exp=0", n);
        end
        send_rx(16'd11, 28'd10100);
        check_pulse("after_flush", 200, 28'd12100);
    endtask

    task automatic test_reset_mid_pulse();
        bit seen;
        seen = 0;
        send_rx(16'd11, 28'd20000);
        tm = 28'd21990;
        for (int i = 0; i < 100 && !seen; i++) begin
            step();
            if (pulse_o) seen = 1;
        end
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL mid_pulse_seen got=0 exp=1");
        end
        rst = 1'b1;
        step();
        checks++;
        if (pulse_o !== 1'b0) begin
            failures++;
            $display("FAIL mid_pulse_reset got=%b exp=0", pulse_o);
        end
        rst = 1'b0;
        step();
        check_reg("post_reset_trx_cnt", 6'h1C, 32'd0);
        check_reg("post_reset_ttx_cnt", 6'h0C, 32'd0);
        check_reg("post_reset_miss", 6'h20, 32'd0);
    endtask

    initial begin
        bus.tx_ready = 1'b0; bus.rx_msg = '0; bus.rx_valid = 1'b0;
        bus.reg_stb = 1'b0; bus.reg_we = 1'b0; bus.reg_addr = '0; bus.reg_wdata = '0;
        test_reset();
        test_regs();
        test_tx();
        test_rx_delay();
        test_wrap();
        test_back_to_back();
        test_fifo_full();
        test_reset_mid_pulse();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
